// File: rtl/z80_mem_model.sv
// rtl/z80_mem_model.sv - Z80 bus memory responder with wait-state insertion, access counters and error flag
// Registered outputs only; storage is never reset so contents survive a bus reset.
module z80_mem_model #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int DEPTH   = 65536,
    parameter int WAIT_RD = 1,
    parameter int WAIT_WR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nMREQ,
    input  logic          nRD,
    input  logic          nWR,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D_in,
    output logic [DW-1:0] D_out,
    output logic          D_oe,
    output logic          nWAIT,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count,
    output logic          err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_is_rd;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_dout;
    logic          r_doe;
    logic          r_nwait;
    logic [15:0]   r_rd_count;
    logic [15:0]   r_wr_count;
    logic          r_err;
    logic [DW-1:0] r_mem [DEPTH];

    state_t        w_state_n;
    logic [3:0]    w_cnt_n;
    logic          w_is_rd_n;
    logic [IW-1:0] w_idx_n;
    logic          w_doe_n;
    logic          w_nwait_n;
    logic          w_err_n;
    logic          w_acc;
    logic          w_acc_rd;
    logic [IW-1:0] w_acc_idx;

    logic          w_start;
    logic          w_clash;
    logic          w_strobe_rd;
    logic          w_all_high;
    logic          w_held;
    logic [3:0]    w_n;
    logic [IW-1:0] w_a_idx;

    assign w_start     = !nMREQ && (nRD != nWR);
    assign w_clash     = !nMREQ && !nRD && !nWR;
    assign w_strobe_rd = !nRD;
    assign w_all_high  = nMREQ && nRD && nWR;
    assign w_n         = w_strobe_rd ? 4'(WAIT_RD) : 4'(WAIT_WR);
    assign w_a_idx     = IW'(32'(A) % 32'(DEPTH));
    // A CPU that drops its strobe while stretched has abandoned the cycle.
    assign w_held      = !nMREQ && (r_is_rd ? !nRD : !nWR);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_is_rd_n = r_is_rd;
        w_idx_n   = r_idx;
        w_doe_n   = r_doe;
        w_nwait_n = r_nwait;
        w_err_n   = r_err;
        w_acc     = 1'b0;
        w_acc_rd  = r_is_rd;
        w_acc_idx = r_idx;

        case (r_state)
            S_IDLE: begin
                if (w_clash) begin
                    w_err_n   = 1'b1;
                    w_state_n = S_HOLD;
                end else if (w_start) begin
                    w_is_rd_n = w_strobe_rd;
                    w_idx_n   = w_a_idx;
                    if (w_n != 4'd0) begin
                        w_cnt_n   = w_n;
                        w_nwait_n = 1'b0;
                        w_state_n = S_WAIT;
                    end else begin
                        w_acc     = 1'b1;
                        w_acc_rd  = w_strobe_rd;
                        w_acc_idx = w_a_idx;
                        w_state_n = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (!w_held) begin
                    w_cnt_n   = 4'd0;
                    w_nwait_n = 1'b1;
                    w_state_n = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_cnt_n   = 4'd0;
                    w_nwait_n = 1'b1;
                    w_acc     = 1'b1;
                    w_state_n = S_ACCESS;
                end else begin
                    w_cnt_n = r_cnt - 4'd1;
                end
            end
            S_ACCESS: begin
                w_state_n = S_HOLD;
            end
            S_HOLD: begin
                if (w_all_high) begin
                    w_doe_n   = 1'b0;
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if (w_acc && w_acc_rd) begin
            w_doe_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_rd    <= 1'b0;
            r_idx      <= '0;
            r_dout     <= '0;
            r_doe      <= 1'b0;
            r_nwait    <= 1'b1;
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_is_rd <= w_is_rd_n;
            r_idx   <= w_idx_n;
            r_doe   <= w_doe_n;
            r_nwait <= w_nwait_n;
            r_err   <= w_err_n;
            if (w_acc && w_acc_rd) begin
                r_dout     <= r_mem[w_acc_idx];
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_acc && !w_acc_rd) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // Storage sits outside the reset domain so a bus reset cannot corrupt it.
    always_ff @(posedge clk) begin
        if (w_acc && !w_acc_rd && !reset) begin
            r_mem[w_acc_idx] <= D_in;
        end
    end

    assign D_out    = r_dout;
    assign D_oe     = r_doe;
    assign nWAIT    = r_nwait;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
    assign err      = r_err;

endmodule

// File: tb/tb_z80_mem_model.sv
// tb/tb_z80_mem_model.sv - scoreboard bench for z80_mem_model
// Stimulus pushes expected completions; a negedge monitor pops them on each DUT completion event.
module tb_z80_mem_model;

    localparam int AW      = 16;
    localparam int DW      = 8;
    localparam int DEPTH   = 256;
    localparam int WAIT_RD = 2;
    localparam int WAIT_WR = 0;

    logic          clk;
    logic          reset;
    logic          nMREQ;
    logic          nRD;
    logic          nWR;
    logic [AW-1:0] A;
    logic [DW-1:0] D_in;
    logic [DW-1:0] D_out;
    logic          D_oe;
    logic          nWAIT;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
    logic          err;

    z80_mem_model #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_RD(WAIT_RD), .WAIT_WR(WAIT_WR)
    ) dut (
        .clk(clk), .reset(reset), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR),
        .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe), .nWAIT(nWAIT),
        .rd_count(rd_count), .wr_count(wr_count), .err(err)
    );

    typedef struct {
        logic        is_rd;
        logic [7:0]  data;
        logic [15:0] rd;
        logic [15:0] wr;
        logic        err;
        int          waits;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_rd   = 16'd0;
    logic [15:0] exp_wr   = 16'd0;
    logic        exp_err  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Caller is just after a negedge; strobes stay low for 'hold' edges then release for two.
    task automatic bus(input logic lo_rd, input logic lo_wr, input logic [15:0] addr,
                       input logic [7:0] wdata, input int hold);
        A     = addr;
        D_in  = wdata;
        nMREQ = 1'b0;
        nRD   = !lo_rd;
        nWR   = !lo_wr;
        repeat (hold) @(negedge clk);
        nMREQ = 1'b1;
        nRD   = 1'b1;
        nWR   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        exp_wr = exp_wr + 16'd1;
        q.push_back('{1'b0, 8'h00, exp_rd, exp_wr, exp_err, WAIT_WR});
        bus(1'b0, 1'b1, addr, data, WAIT_WR + 1);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] expdata);
        exp_rd = exp_rd + 16'd1;
        q.push_back('{1'b1, expdata, exp_rd, exp_wr, exp_err, WAIT_RD});
        bus(1'b1, 1'b0, addr, 8'h00, WAIT_RD + 1);
    endtask

    task automatic do_clash(input logic [15:0] addr, input logic [7:0] data);
        exp_err = 1'b1;
        q.push_back('{1'b0, 8'h00, exp_rd, exp_wr, exp_err, 0});
        bus(1'b1, 1'b1, addr, data, 1);
    endtask

    initial begin : monitor
        logic        prev_doe;
        logic        prev_err;
        logic [15:0] prev_rd;
        logic [15:0] prev_wr;
        int          wait_lo;
        exp_t        e;
        prev_doe = 1'b0;
        prev_err = 1'b0;
        prev_rd  = 16'd0;
        prev_wr  = 16'd0;
        wait_lo  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wait_lo  = 0;
                prev_doe = D_oe;
                prev_err = err;
                prev_rd  = rd_count;
                prev_wr  = wr_count;
                continue;
            end
            if (!nWAIT) wait_lo++;
            if ((D_oe && !prev_doe) || (rd_count != prev_rd) ||
                (wr_count != prev_wr) || (err && !prev_err)) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: rd=%0h wr=%0h err=%0b with no expectation queued",
                             rd_count, wr_count, err);
                end else begin
                    e = q.pop_front();
                    if (e.is_rd) begin
                        check("rd_data", 32'(D_out), 32'(e.data));
                        check("rd_oe", 32'(D_oe), 32'd1);
                    end
                    check("rd_count", 32'(rd_count), 32'(e.rd));
                    check("wr_count", 32'(wr_count), 32'(e.wr));
                    check("err", 32'(err), 32'(e.err));
                    check("wait_cycles", 32'(wait_lo), 32'(e.waits));
                end
                wait_lo = 0;
            end
            prev_doe = D_oe;
            prev_err = err;
            prev_rd  = rd_count;
            prev_wr  = wr_count;
        end
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before stimulus completed");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        reset = 1'b1;
        nMREQ = 1'b1;
        nRD   = 1'b1;
        nWR   = 1'b1;
        A     = '0;
        D_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_nwait", 32'(nWAIT), 32'd1);
        check("reset_doe", 32'(D_oe), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_nwait", 32'(nWAIT), 32'd1);
        check("idle_doe", 32'(D_oe), 32'd0);
        check("idle_dout", 32'(D_out), 32'd0);
        check("idle_rd_count", 32'(rd_count), 32'd0);
        check("idle_wr_count", 32'(wr_count), 32'd0);
        check("idle_err", 32'(err), 32'd0);

        // Refresh cycle: nMREQ alone must be ignored.
        nMREQ = 1'b0;
        repeat (2) @(negedge clk);
        check("refresh_nwait", 32'(nWAIT), 32'd1);
        check("refresh_doe", 32'(D_oe), 32'd0);
        nMREQ = 1'b1;
        repeat (2) @(negedge clk);

        do_write(16'h1234, 8'hA5);
        do_read(16'h1234, 8'hA5);

        do_write(16'h0010, 8'h3C);
        do_read(16'hFF10, 8'h3C);

        do_clash(16'h0010, 8'hFF);
        do_read(16'h0010, 8'h3C);
        do_write(16'h0055, 8'h77);
        do_read(16'h0055, 8'h77);
        check("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a stretched read.
        A     = 16'h1234;
        nMREQ = 1'b0;
        nRD   = 1'b0;
        @(negedge clk);
        check("abort_in_wait", 32'(nWAIT), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort_nwait", 32'(nWAIT), 32'd1);
        check("abort_doe", 32'(D_oe), 32'd0);
        check("abort_rd_count", 32'(rd_count), 32'd0);
        check("abort_wr_count", 32'(wr_count), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        nMREQ   = 1'b1;
        nRD     = 1'b1;
        exp_rd  = 16'd0;
        exp_wr  = 16'd0;
        exp_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_read(16'h1234, 8'hA5);

        // Jump the write counter near its wrap point instead of issuing 65534 real writes.
        exp_wr = 16'hFFFE;
        q.push_back('{1'b0, 8'h00, exp_rd, exp_wr, exp_err, 0});
        #1 force dut.r_wr_count = 16'hFFFE;
        #1 release dut.r_wr_count;
        @(negedge clk);
        do_write(16'h0001, 8'h11);
        do_write(16'h0002, 8'h22);
        check("wrap_wr_count", 32'(wr_count), 32'd0);
        check("wrap_rd_count", 32'(rd_count), 32'd1);
        do_read(16'h0001, 8'h11);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
